// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial MSB-first pattern transmitter with repeat count and idle gaps
module seq_pattern_gen #(
    parameter int   WIDTH      = 8,
    parameter int   LEN_W      = 4,
    parameter int   CNT_W      = 4,
    parameter int   GAP_CYC    = 1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             dout,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d, bit_q, bit_d, eff_len;
    logic [CNT_W-1:0] copy_q, copy_d;
    logic [GW-1:0] gap_q, gap_d;

    assign eff_len = (len > MAX_LEN) ? MAX_LEN : len;
    assign dout    = (state_q == SHIFT) ? sh_q[WIDTH-1] : IDLE_LEVEL;
    assign valid   = state_q == SHIFT;
    assign busy    = state_q == SHIFT || state_q == GAP;
    assign done    = state_q == DONE;

    // The used field is left-aligned at latch time so every copy shifts out of the MSB.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        pat_d   = pat_q;
        len_d   = len_q;
        bit_d   = bit_q;
        copy_d  = copy_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: if (start) begin
                pat_d   = pattern << (MAX_LEN - eff_len);
                sh_d    = pat_d;
                len_d   = eff_len;
                bit_d   = eff_len;
                copy_d  = repeat_cnt;
                state_d = (eff_len == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                sh_d  = sh_q << 1;
                bit_d = bit_q - 1'b1;
                if (bit_q == LEN_W'(1)) begin
                    if (copy_q != '0) begin
                        copy_d  = copy_q - 1'b1;
                        sh_d    = pat_q;
                        bit_d   = len_q;
                        gap_d   = GAP_LOAD;
                        state_d = (GAP_CYC > 0) ? GAP : SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            GAP: begin
                gap_d   = gap_q - 1'b1;
                state_d = (gap_q == '0) ? SHIFT : GAP;
            end
            DONE: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            copy_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            copy_q  <= copy_d;
            gap_q   <= gap_d;
        end
    end
endmodule
